// File: rtl/generic_sfifo.sv
// rtl/generic_sfifo.sv - single-clock FIFO with registered read data, level and status flags
// Optional sticky ovf/unf error flags are enabled by defining GENERIC_SFIFO_ERR_FLAGS_EN.
module generic_sfifo #(
    parameter int aw     = 5,
    parameter int dw     = 16,
    parameter int af_lvl = (1 << aw) - 2,
    parameter int ae_lvl = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [dw-1:0] di,
    input  logic          re,
    output logic [dw-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [aw:0]   level,
    output logic          ovf,
    output logic          unf
);

    localparam int depth = 1 << aw;
    localparam logic [aw:0] af_thr = af_lvl[aw:0];
    localparam logic [aw:0] ae_thr = ae_lvl[aw:0];

    logic [dw-1:0] mem [depth];
    logic [aw:0]   wptr;
    logic [aw:0]   rptr;
    logic          wr_acc;
    logic          rd_acc;

    assign empty        = (wptr == rptr);
    assign full         = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    assign almost_full  = (level >= af_thr);
    assign almost_empty = (level <= ae_thr);

    // Full gates writes and empty gates reads, so both never touch the same entry.
    assign wr_acc = we && !full && !clr;
    assign rd_acc = re && !empty && !clr;

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wptr[aw-1:0]] <= di;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            dout  <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
                dout <= mem[rptr[aw-1:0]];
            end
            level <= level + {{aw{1'b0}}, wr_acc} - {{aw{1'b0}}, rd_acc};
        end
    end

`ifdef GENERIC_SFIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (we && full) begin
                ovf <= 1'b1;
            end
            if (re && empty) begin
                unf <= 1'b1;
            end
        end
    end
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_generic_sfifo.sv
// tb/tb_generic_sfifo.sv - scoreboard bench for generic_sfifo (aw=5, dw=16)
module tb_generic_sfifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        we;
    logic [15:0] di;
    logic        re;
    logic [15:0] dout;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [5:0]  level;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] model_do;
    logic        model_ovf;
    logic        model_unf;
    logic        rd_pending = 1'b0;

    generic_sfifo #(.aw(5), .dw(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .di(di), .re(re),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .level(level), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: a read accepted at the last edge must present its entry now.
    always @(negedge clk) begin
        if (rd_pending) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: actual=0x%0h expected=<none queued>", dout);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL rd_data: actual=0x%0h expected=0x%0h", dout, e);
                end
            end
        end
    end

    task automatic step(input logic r_n, input logic c, input logic w,
                        input logic [15:0] d, input logic r);
        logic wa, ra, pend;
        int   sz;
        rst_n = r_n; clr = c; we = w; di = d; re = r;
        pend = 1'b0;
        sz = model_q.size();
        wa = w && (sz < 32);
        ra = r && (sz > 0);
        if (!r_n) begin
            model_q.delete();
            model_do  = '0;
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
`ifdef GENERIC_SFIFO_ERR_FLAGS_EN
            if (w && sz == 32) model_ovf = 1'b1;
            if (r && sz == 0)  model_unf = 1'b1;
`endif
            if (c) begin
                model_q.delete();
            end else begin
                if (ra) begin
                    model_do = model_q.pop_front();
                    exp_q.push_back(model_do);
                    pend = 1'b1;
                end
                if (wa) model_q.push_back(d);
            end
        end
        @(posedge clk);
        rd_pending = pend;
        @(negedge clk);
    endtask

    task automatic chk_status(input string tag);
        int sz;
        sz = model_q.size();
        chk({tag, ".level"}, int'(level), sz);
        chk({tag, ".empty"}, int'(empty), int'(sz == 0));
        chk({tag, ".full"}, int'(full), int'(sz == 32));
        chk({tag, ".almost_full"}, int'(almost_full), int'(sz >= 30));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(sz <= 2));
        chk({tag, ".ovf"}, int'(ovf), int'(model_ovf));
        chk({tag, ".unf"}, int'(unf), int'(model_unf));
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; we = 1'b0; di = '0; re = 1'b0;
        model_do = '0; model_ovf = 1'b0; model_unf = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        chk_status("reset");
        chk("reset.empty_const", int'(empty), 1);
        chk("reset.almost_empty_const", int'(almost_empty), 1);
        chk("reset.do", int'(dout), 0);

        // Fill with 0x0000..0x001F.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'(i), 1'b0);
            chk_status("fill");
            if (i == 28) chk("fill.af_at_29", int'(almost_full), 0);
            if (i == 29) chk("fill.af_at_30", int'(almost_full), 1);
        end
        chk("fill.full_const", int'(full), 1);
        chk("fill.level_const", int'(level), 32);

        // Write while full: dropped, overflow flagged when enabled.
        step(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        chk_status("ovf");
        chk("ovf.level_const", int'(level), 32);
`ifdef GENERIC_SFIFO_ERR_FLAGS_EN
        chk("ovf.flag_const", int'(ovf), 1);
`else
        chk("ovf.flag_const", int'(ovf), 0);
`endif

        // Full with we+re: read accepted, write dropped.
        step(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk_status("full_we_re");
        chk("full_we_re.level_const", int'(level), 31);

        // Drain the rest.
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
            chk_status("drain");
        end
        chk("drain.empty_const", int'(empty), 1);
        chk("drain.last_do", int'(dout), 16'h001F);

        // Read on empty: ignored, underflow flagged when enabled.
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk_status("unf");
        chk("unf.do_unchanged", int'(dout), 16'h001F);
`ifdef GENERIC_SFIFO_ERR_FLAGS_EN
        chk("unf.flag_const", int'(unf), 1);
`else
        chk("unf.flag_const", int'(unf), 0);
`endif

        // Empty with we+re: write accepted, read ignored.
        step(1'b1, 1'b0, 1'b1, 16'h0100, 1'b1);
        chk_status("empty_we_re");
        chk("empty_we_re.do_unchanged", int'(dout), 16'h001F);
        for (int i = 1; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
        end
        chk("lvl10.level_const", int'(level), 10);

        // Steady streaming across pointer wrap.
        for (int i = 10; i < 110; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'(16'h0100 + i), 1'b1);
            chk("stream.level", int'(level), 10);
        end

        // Down to level 5, then flush with a competing write.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("pre_clr.level", int'(level), 5);
        step(1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b0);
        chk_status("clr");
        chk("clr.level_const", int'(level), 0);
        chk("clr.do_unchanged", int'(dout), int'(model_do));

        // Reset mid-burst.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 16'(16'h0200 + i), 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
        chk_status("mid_reset");
        chk("mid_reset.do", int'(dout), 0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("post_reset.level", int'(level), 0);
        chk("scoreboard.drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/generic_sfifo.md
GENERIC_SFIFO -- requirements
Module: generic_sfifo

Interface
REQ-001 The block SHALL have parameter aw, default 5, address bits; depth SHALL be 2^aw entries.
REQ-002 The block SHALL have parameter dw, default 16, data bits per entry.
REQ-003 The block SHALL have parameter af_lvl, default 2^aw-2, almost-full threshold in entries.
REQ-004 The block SHALL have parameter ae_lvl, default 2, almost-empty threshold in entries.
REQ-005 Port clk, input, 1: single clock, rising edge; all logic SHALL be clocked by clk.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port clr, input, 1: synchronous flush, active high.
REQ-008 Port we, input, 1: write request.
REQ-009 Port di, input, dw: write data.
REQ-010 Port re, input, 1: read request.
REQ-011 Port do, output, dw: registered read data.
REQ-012 Port full, empty, almost_full, almost_empty, output, 1 each: status flags.
REQ-013 Port level, output, aw+1: current entry count, 0..2^aw.
REQ-014 Port ovf, unf, output, 1 each: sticky overflow/underflow error flags.

Function
REQ-015 Write SHALL be accepted when we=1 and full=0; di is stored at the write pointer, which advances by 1.
REQ-016 Read SHALL be accepted when re=1 and empty=0; the read pointer advances by 1 and do updates on the same clk edge with the entry at the old read pointer (1-cycle latency from re).
REQ-017 do SHALL hold its value between accepted reads.
REQ-018 Pointers SHALL be aw+1 bits and wrap modulo 2^(aw+1); the MSB distinguishes full from empty.
REQ-019 empty SHALL be 1 iff the pointers are equal; full SHALL be 1 iff the low aw bits are equal and the MSBs differ.
REQ-020 level SHALL equal wptr-rptr modulo 2^(aw+1) and be registered, updating on the same edge as the pointers.
REQ-021 almost_full SHALL be 1 iff level>=af_lvl; almost_empty SHALL be 1 iff level<=ae_lvl.
REQ-022 When write and read are accepted in the same cycle, level SHALL be unchanged and both pointers SHALL advance.
REQ-023 When empty, we=1 and re=1: the write SHALL be accepted, the read ignored, and do unchanged.
REQ-024 When full, we=1 and re=1: the read SHALL be accepted, the write ignored, and the data dropped.
REQ-025 Rejected requests SHALL NOT change the pointers, level or memory.
REQ-026 clr=1 SHALL zero both pointers and level on the next edge and override we/re in that cycle; memory contents, do, ovf and unf SHALL be unaffected.
REQ-027 Read data SHALL never be X: accepted read and write never address the same entry in one cycle.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force wptr=0, rptr=0, level=0, do=0, ovf=0 and unf=0, giving empty=1, full=0 and almost_empty=1.
REQ-029 Reset SHALL take priority over clr, we and re; an in-flight read is discarded.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 With macro GENERIC_SFIFO_ERR_FLAGS_EN defined, ovf SHALL set on we=1 while full=0 is not met (full=1 and no accepted write), unf SHALL set on re=1 while empty=1, and both SHALL clear only on reset.
REQ-032 Without GENERIC_SFIFO_ERR_FLAGS_EN, ovf and unf SHALL be constant 0 and no error registers SHALL exist.

Verification
REQ-033 Reset, then 32 writes of 0x0000..0x001F with aw=5 -> full=1 after the 32nd edge, level=32, almost_full set at level 30.
REQ-034 32 reads -> do sequence 0x0000..0x001F, each valid 1 cycle after re; empty=1 after the last, almost_empty at level 2.
REQ-035 Simultaneous we/re at level 10 for 100 cycles (pointer wrap) -> level stays 10 and data order is preserved.
REQ-036 With the FIFO full, we=1 with di=0xBEEF -> data dropped, ovf=1 (macro on) or 0 (macro off); re on empty -> unf likewise, do unchanged.
REQ-037 Level 5, clr=1 with we=1 -> next cycle level=0, empty=1, do unchanged; rst_n=0 mid-burst -> do=0 and flags reset on the next edge.
